// File: rtl/wshb_frame_reader_if.sv
// Wishbone classic/burst signal bundle between the frame reader (master) and the SDRAM slave.
interface wshb_frame_reader_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic [31:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, sel, cti, bte,
    input  ack, err, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte,
    output ack, err, dat_sm
  );
endinterface

// File: rtl/wshb_frame_reader.sv
// Wishbone burst reader streaming a framebuffer from SDRAM into the pixel FIFO.
// Define FRAME_READER_STATS_EN to add the frame_cnt / err_cnt outputs.
//
// state   | meaning
// S_IDLE  | disabled, no bus activity
// S_WAIT  | enabled, waiting for FIFO room to start the next burst
// S_BURST | incrementing read burst in progress (cyc=stb=1)
module wshb_frame_reader #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned BURST     = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  wshb_frame_reader_if.master wb,
  input  logic        fifo_room,
  output logic [31:0] pix_data,
  output logic        pix_wr,
  output logic        frame_start
`ifdef FRAME_READER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam int unsigned NPIX   = HDISP * VDISP;
  localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned BEAT_W = $clog2(BURST);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       pix_data_q, pix_data_d;
  logic              pix_wr_q, pix_wr_d;
  logic              frame_start_q, frame_start_d;
  logic              last_beat;
`ifdef FRAME_READER_STATS_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  // A burst ends on its nominal last beat or early at the frame's last pixel.
  assign last_beat = (beat_q == LAST_BEAT) || (pix_idx_q == LAST_PIX);

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    pix_idx_d     = pix_idx_q;
    beat_d        = beat_q;
    pix_data_d    = pix_data_q;
    pix_wr_d      = 1'b0;
    frame_start_d = 1'b0;
`ifdef FRAME_READER_STATS_EN
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (fifo_room) begin
          state_d       = S_BURST;
          frame_start_d = (pix_idx_q == '0);
        end
      end
      S_BURST: begin
        if (wb.err) begin
          // Abandon the frame; the next burst restarts at pixel 0.
          state_d   = S_WAIT;
          pix_idx_d = '0;
          adr_d     = BASE_ADDR;
          beat_d    = '0;
`ifdef FRAME_READER_STATS_EN
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
        end else if (wb.ack) begin
          pix_wr_d   = 1'b1;
          pix_data_d = wb.dat_sm;
          beat_d     = beat_q + BEAT_W'(1);
          if (pix_idx_q == LAST_PIX) begin
            pix_idx_d = '0;
            adr_d     = BASE_ADDR;
`ifdef FRAME_READER_STATS_EN
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
          end else begin
            pix_idx_d = pix_idx_q + PIX_W'(1);
            adr_d     = adr_q + 32'd4;
          end
          if (last_beat) begin
            state_d = S_WAIT;
            beat_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      adr_q         <= BASE_ADDR;
      pix_idx_q     <= '0;
      beat_q        <= '0;
      pix_data_q    <= '0;
      pix_wr_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef FRAME_READER_STATS_EN
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      pix_idx_q     <= pix_idx_d;
      beat_q        <= beat_d;
      pix_data_q    <= pix_data_d;
      pix_wr_q      <= pix_wr_d;
      frame_start_q <= frame_start_d;
`ifdef FRAME_READER_STATS_EN
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
`endif
    end
  end

  assign wb.cyc      = (state_q == S_BURST);
  assign wb.stb      = (state_q == S_BURST);
  assign wb.we       = 1'b0;
  assign wb.sel      = 4'hF;
  assign wb.bte      = 2'b00;
  assign wb.adr      = adr_q;
  assign wb.cti      = (state_q != S_BURST) ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
  assign pix_data    = pix_data_q;
  assign pix_wr      = pix_wr_q;
  assign frame_start = frame_start_q;
`ifdef FRAME_READER_STATS_EN
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench for wshb_frame_reader: two instances (4x2 and 3x2 frames, BURST=4) driven by a bus slave model.
module tb_wshb_frame_reader;
  localparam int BURST = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_room = 1'b1;
  logic        use_b = 1'b0;
  logic        ack_r = 1'b0;
  logic        err_r = 1'b0;
  logic [31:0] dat_r = '0;

  logic [31:0] pix_data_a, pix_data_b;
  logic        pix_wr_a, pix_wr_b, frame_start_a, frame_start_b;
`ifdef FRAME_READER_STATS_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic [7:0]  err_cnt_a, err_cnt_b;
`endif

  wshb_frame_reader_if bus_a ();
  wshb_frame_reader_if bus_b ();

  assign bus_a.ack    = ack_r && !use_b;
  assign bus_a.err    = err_r && !use_b;
  assign bus_a.dat_sm = dat_r;
  assign bus_b.ack    = ack_r && use_b;
  assign bus_b.err    = err_r && use_b;
  assign bus_b.dat_sm = dat_r;

  always #5 sys_clk = ~sys_clk;

  wshb_frame_reader #(.HDISP(4), .VDISP(2), .BASE_ADDR(32'h0), .BURST(BURST)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable && !use_b), .wb(bus_a),
    .fifo_room(fifo_room), .pix_data(pix_data_a), .pix_wr(pix_wr_a), .frame_start(frame_start_a)
`ifdef FRAME_READER_STATS_EN
    , .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a)
`endif
  );

  wshb_frame_reader #(.HDISP(3), .VDISP(2), .BASE_ADDR(32'h0), .BURST(BURST)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable && use_b), .wb(bus_b),
    .fifo_room(fifo_room), .pix_data(pix_data_b), .pix_wr(pix_wr_b), .frame_start(frame_start_b)
`ifdef FRAME_READER_STATS_EN
    , .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference model: next expected pixel and frame size of the selected instance.
  int m_pix;
  int npix;

  // Observations of the most recent burst.
  logic [31:0] b_adr [64];
  logic [2:0]  b_cti [64];
  logic [31:0] b_dat [64];
  logic [31:0] w_dat [64];
  int n_beats, n_wr, wait_cycles;
  bit timed_out, stb_gap, lat_bad, fs_at_start;

  function automatic logic cur_cyc();  return use_b ? bus_b.cyc : bus_a.cyc; endfunction
  function automatic logic cur_stb();  return use_b ? bus_b.stb : bus_a.stb; endfunction
  function automatic logic [31:0] cur_adr(); return use_b ? bus_b.adr : bus_a.adr; endfunction
  function automatic logic [2:0] cur_cti(); return use_b ? bus_b.cti : bus_a.cti; endfunction
  function automatic logic cur_wr();   return use_b ? pix_wr_b : pix_wr_a; endfunction
  function automatic logic [31:0] cur_pd(); return use_b ? pix_data_b : pix_data_a; endfunction
  function automatic logic cur_fs();   return use_b ? frame_start_b : frame_start_a; endfunction

  function automatic int exp_len();
    return (npix - m_pix < BURST) ? (npix - m_pix) : BURST;
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0; enable = 1'b0; ack_r = 1'b0; err_r = 1'b0; fifo_room = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_pix = 0;
    @(negedge sys_clk);
  endtask

  // Bus slave: waits for cyc, then acks (period 1/3, or random when 0) and records what it sees.
  task automatic serve_burst(input int ack_period, input int err_beat);
    int ph, cnt;
    bit exp_wr, do_ack;
    logic [31:0] d;
    n_beats = 0; n_wr = 0; timed_out = 0; stb_gap = 0; lat_bad = 0;
    wait_cycles = 0;
    while (!cur_cyc() && wait_cycles < 200) begin
      @(negedge sys_clk);
      wait_cycles++;
    end
    if (!cur_cyc()) begin
      timed_out = 1;
      return;
    end
    fs_at_start = cur_fs();
    ph = 0; cnt = 0;
    while (cur_cyc() && cnt < 400) begin
      if (!cur_stb()) stb_gap = 1;
      exp_wr = 0;
      if (ack_period == 0) begin
        do_ack = ($urandom_range(0, 1) == 1);
      end else begin
        ph++;
        do_ack = (ph >= ack_period);
        if (do_ack) ph = 0;
      end
      if (do_ack) begin
        d = $urandom;
        if (n_beats < 64) begin
          b_adr[n_beats] = cur_adr(); b_cti[n_beats] = cur_cti(); b_dat[n_beats] = d;
        end
        if (n_beats == err_beat) err_r = 1'b1;
        else begin
          ack_r = 1'b1;
          exp_wr = 1;
        end
        dat_r = d;
        n_beats++;
      end
      @(negedge sys_clk);
      ack_r = 1'b0; err_r = 1'b0; cnt++;
      if (cur_wr() !== exp_wr) lat_bad = 1;
      if (cur_wr() && n_wr < 64) w_dat[n_wr] = cur_pd();
      if (cur_wr()) n_wr++;
    end
  endtask

  task automatic test_reset();
    use_b = 0;
    do_reset();
    total++; if (bus_a.cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc: got %b want 0", bus_a.cyc); end
    total++; if (bus_a.stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", bus_a.stb); end
    total++; if (bus_a.adr !== 32'h0) begin bad++; $display("FAIL reset_adr: got %h want 0", bus_a.adr); end
    total++; if (bus_a.cti !== 3'b000) begin bad++; $display("FAIL reset_cti: got %b want 000", bus_a.cti); end
    total++; if (pix_wr_a !== 1'b0) begin bad++; $display("FAIL reset_pix_wr: got %b want 0", pix_wr_a); end
    total++; if (pix_data_a !== 32'h0) begin bad++; $display("FAIL reset_pix_data: got %h want 0", pix_data_a); end
    total++; if (frame_start_a !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start_a); end
    total++; if ({bus_a.we, bus_a.sel, bus_a.bte} !== 7'b0_1111_00) begin
      bad++; $display("FAIL const_we_sel_bte: got %b want 0111100", {bus_a.we, bus_a.sel, bus_a.bte});
    end
  endtask

  task automatic test_basic_frame();
    int len;
    use_b = 0; npix = 8;
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      len = exp_len();
      serve_burst(1, -1);
      total++; if (timed_out) begin bad++; $display("FAIL basic_timeout: burst %0d never started", b); end
      total++; if (n_beats !== len) begin bad++; $display("FAIL basic_len: got %0d want %0d", n_beats, len); end
      total++; if (n_wr !== len) begin bad++; $display("FAIL basic_pix_wr: got %0d want %0d", n_wr, len); end
      total++; if (fs_at_start !== (m_pix == 0)) begin
        bad++; $display("FAIL basic_frame_start: got %b want %b", fs_at_start, (m_pix == 0));
      end
      for (int i = 0; i < len && i < n_beats; i++) begin
        total++; if (b_adr[i] !== 32'(4 * (m_pix + i))) begin
          bad++; $display("FAIL basic_adr: got %h want %h", b_adr[i], 32'(4 * (m_pix + i)));
        end
        total++; if (b_cti[i] !== ((i == len - 1) ? 3'b111 : 3'b010)) begin
          bad++; $display("FAIL basic_cti: beat %0d got %b want %b", i, b_cti[i], (i == len - 1) ? 3'b111 : 3'b010);
        end
      end
      m_pix = (m_pix + len) % npix;
    end
`ifdef FRAME_READER_STATS_EN
    total++; if (frame_cnt_a !== 16'd1) begin bad++; $display("FAIL frame_cnt: got %0d want 1", frame_cnt_a); end
`endif
    enable = 1'b0;
  endtask

  task automatic test_wait_states();
    int len;
    use_b = 0; npix = 8;
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 2; b++) begin
      len = exp_len();
      serve_burst(3, -1);
      total++; if (stb_gap) begin bad++; $display("FAIL ws_stb: got stb low want stb high during cyc"); end
      total++; if (lat_bad) begin bad++; $display("FAIL ws_latency: got pix_wr off ack+1 want pix_wr exactly ack+1"); end
      total++; if (n_wr !== len) begin bad++; $display("FAIL ws_pix_wr: got %0d want %0d", n_wr, len); end
      for (int i = 0; i < len && i < n_wr; i++) begin
        total++; if (w_dat[i] !== b_dat[i]) begin bad++; $display("FAIL ws_data: got %h want %h", w_dat[i], b_dat[i]); end
      end
      m_pix = (m_pix + len) % npix;
    end
    enable = 1'b0;
  endtask

  task automatic test_back_pressure();
    int cyc_seen;
    use_b = 0; npix = 8;
    do_reset();
    enable = 1'b1;
    serve_burst(1, -1);
    fifo_room = 1'b0;
    cyc_seen = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (bus_a.cyc) cyc_seen++;
    end
    total++; if (cyc_seen !== 0) begin bad++; $display("FAIL bp_cyc: got %0d cyc cycles want 0", cyc_seen); end
    fifo_room = 1'b1;
    serve_burst(1, -1);
    total++; if (wait_cycles !== 1) begin bad++; $display("FAIL bp_start: got %0d cycles want 1", wait_cycles); end
    total++; if (b_adr[0] !== 32'h10) begin bad++; $display("FAIL bp_adr: got %h want 00000010", b_adr[0]); end
    enable = 1'b0;
  endtask

  task automatic test_non_multiple();
    int len;
    use_b = 1; npix = 6;
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      len = exp_len();
      serve_burst(1, -1);
      total++; if (n_beats !== len) begin bad++; $display("FAIL nm_len: got %0d want %0d", n_beats, len); end
      total++; if (b_adr[0] !== 32'(4 * m_pix)) begin bad++; $display("FAIL nm_adr0: got %h want %h", b_adr[0], 32'(4 * m_pix)); end
      if (n_beats >= len && len > 0) begin
        total++; if (b_cti[len-1] !== 3'b111) begin bad++; $display("FAIL nm_cti_last: got %b want 111", b_cti[len-1]); end
        total++; if (b_adr[len-1] !== 32'(4 * (m_pix + len - 1))) begin
          bad++; $display("FAIL nm_adr_last: got %h want %h", b_adr[len-1], 32'(4 * (m_pix + len - 1)));
        end
      end
      m_pix = (m_pix + len) % npix;
    end
    enable = 1'b0;
  endtask

  task automatic test_random_waits();
    int len;
    use_b = 1; npix = 6;
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 6; b++) begin
      len = exp_len();
      serve_burst(0, -1);
      total++; if (lat_bad || n_wr !== len) begin bad++; $display("FAIL rnd_pix_wr: got %0d lat_bad=%0d want %0d", n_wr, lat_bad, len); end
      for (int i = 0; i < len && i < n_wr && i < n_beats; i++) begin
        total++; if (w_dat[i] !== b_dat[i] || b_adr[i] !== 32'(4 * (m_pix + i))) begin
          bad++; $display("FAIL rnd_beat: got adr %h data %h want adr %h data %h", b_adr[i], w_dat[i], 32'(4 * (m_pix + i)), b_dat[i]);
        end
      end
      m_pix = (m_pix + len) % npix;
    end
    enable = 1'b0;
  endtask

  task automatic test_error();
    use_b = 0; npix = 8;
    do_reset();
    enable = 1'b1;
    serve_burst(1, -1);
    serve_burst(1, 2);
    total++; if (n_beats !== 3) begin bad++; $display("FAIL err_beats: got %0d want 3", n_beats); end
    total++; if (n_wr !== 2) begin bad++; $display("FAIL err_pix_wr: got %0d want 2", n_wr); end
    total++; if (lat_bad) begin bad++; $display("FAIL err_wr_timing: got pix_wr on err beat want none"); end
    m_pix = 0;
    serve_burst(1, -1);
    total++; if (b_adr[0] !== 32'h0) begin bad++; $display("FAIL err_restart_adr: got %h want 0", b_adr[0]); end
    total++; if (fs_at_start !== 1'b1) begin bad++; $display("FAIL err_frame_start: got %b want 1", fs_at_start); end
`ifdef FRAME_READER_STATS_EN
    total++; if (err_cnt_a !== 8'd1) begin bad++; $display("FAIL err_cnt: got %0d want 1", err_cnt_a); end
`endif
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int w;
    use_b = 0;
    do_reset();
    enable = 1'b1;
    w = 0;
    while (!bus_a.cyc && w < 50) begin
      @(negedge sys_clk);
      w++;
    end
    total++; if (bus_a.cyc !== 1'b1) begin bad++; $display("FAIL rst_burst_start: got cyc %b want 1", bus_a.cyc); end
    ack_r = 1'b1; dat_r = $urandom | 32'h1;
    @(negedge sys_clk);
    ack_r = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    total++; if ({bus_a.cyc, bus_a.stb} !== 2'b00) begin bad++; $display("FAIL rst_async_cyc: got %b want 00", {bus_a.cyc, bus_a.stb}); end
    total++; if (pix_data_a !== 32'h0 || pix_wr_a !== 1'b0) begin
      bad++; $display("FAIL rst_async_pix: got %h/%b want 0/0", pix_data_a, pix_wr_a);
    end
    enable = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    total++; if (bus_a.cyc !== 1'b0 || bus_a.adr !== 32'h0) begin
      bad++; $display("FAIL rst_idle: got cyc %b adr %h want 0 00000000", bus_a.cyc, bus_a.adr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_wait_states();
    test_back_pressure();
    test_non_multiple();
    test_random_waits();
    test_error();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
